// File: rtl/sincos_scheduler.sv
// Time-shares one sin/cos evaluator: each accepted phase is evaluated as sin, then cos,
// and the captured pair is presented on a valid/ready output for the Box-Muller stage.
module sincos_scheduler #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TRIG_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_phase,
    output logic              trig_func,
    output logic [DATA_W-1:0] trig_x,
    input  logic [DATA_W-1:0] trig_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sin,
    output logic [DATA_W-1:0] out_cos,
    output logic              busy,
    output logic [CNT_W-1:0]  pair_count
);

    localparam int unsigned CW = (TRIG_LAT < 1) ? 1 : $clog2(TRIG_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TRIG_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIN  = 2'd1,
        COS  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               func_q, func_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  sin_q, sin_d;
    logic [DATA_W-1:0]  cos_q, cos_d;
    logic [CNT_W-1:0]   pc_q, pc_d;

    // State register; synchronous reset discards any in-flight phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= 1'b0;
            x_q     <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            x_q     <= x_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: capture the evaluator once cnt reaches its latency, sin first then cos.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        x_d     = x_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_phase;
                    func_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SIN;
                end
            end
            SIN: begin
                if (cnt_q == CNT_LAST) begin
                    sin_d   = trig_value;
                    func_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = COS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            COS: begin
                if (cnt_q == CNT_LAST) begin
                    cos_d   = trig_value;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    pc_d    = pc_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE) & ~reset;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign trig_func  = func_q;
    assign trig_x     = x_q;
    assign out_sin    = sin_q;
    assign out_cos    = cos_q;
    assign pair_count = pc_q;

endmodule

// File: tb/tb_sincos_scheduler.sv
// Bench for sincos_scheduler: three builds (TRIG_LAT 1/0/3) each with a delayed
// evaluator stub returning func ? ~x : x, checked against a scoreboard of expected pairs.
module tb_sincos_scheduler;

    localparam int NI = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [NI];
    logic        iv   [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic        tf   [NI];
    logic        bsy  [NI];
    logic [15:0] ph   [NI];
    logic [15:0] tx   [NI];
    logic [15:0] tv   [NI];
    logic [15:0] os   [NI];
    logic [15:0] oc   [NI];
    logic [15:0] pc   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
        localparam int unsigned CW  = (g == 1) ? 4 : 16;
        logic [CW-1:0] pc_raw;
        logic [15:0]   f;

        sincos_scheduler #(.DATA_W(16), .TRIG_LAT(LAT), .CNT_W(CW)) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .in_valid   (iv[g]),
            .in_ready   (ir[g]),
            .in_phase   (ph[g]),
            .trig_func  (tf[g]),
            .trig_x     (tx[g]),
            .trig_value (tv[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .out_sin    (os[g]),
            .out_cos    (oc[g]),
            .busy       (bsy[g]),
            .pair_count (pc_raw)
        );
        assign pc[g] = 16'(pc_raw);
        assign f = tf[g] ? ~tx[g] : tx[g];

        if (LAT == 0) begin : g_comb
            assign tv[g] = f;
        end else begin : g_pipe
            logic [15:0] pipe [LAT];
            always @(posedge clk) begin
                pipe[0] <= f;
                for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
            end
            assign tv[g] = pipe[LAT-1];
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          exp_pc [NI];
    logic [31:0] exp_q [$];
    logic [15:0] phs_q [$];

    function automatic int pc_mask(int g);
        return (g == 1) ? 32'h000F : 32'hFFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(int g);
        rst[g] = 1'b1;
        iv[g]  = 1'b0;
        #1;
        check("in_ready_in_reset", 32'(ir[g]), 0);
        step();
        step();
        rst[g] = 1'b0;
        #1;
        exp_q.delete();
        exp_pc[g] = 0;
        check("rst_out_valid", 32'(ov[g]), 0);
        check("rst_busy", 32'(bsy[g]), 0);
        check("rst_trig_x", 32'(tx[g]), 0);
        check("rst_trig_func", 32'(tf[g]), 0);
        check("rst_out_sin", 32'(os[g]), 0);
        check("rst_out_cos", 32'(oc[g]), 0);
        check("rst_pair_count", 32'(pc[g]), 0);
        check("rst_in_ready", 32'(ir[g]), 1);
    endtask

    // Feeds phs_q with in_valid held, scoreboards every pair, reports latency and pair period.
    task automatic run(int g, int max_cyc, output int lat, output int per);
        int          pidx = 0;
        int          ndone = 0;
        int          n = phs_q.size();
        int          c0 = cyc;
        int          acc_cyc = -1;
        int          last_done = -1;
        logic [31:0] e;
        lat = -1;
        per = -1;
        while (ndone < n && (cyc - c0) < max_cyc) begin
            iv[g] = (pidx < n);
            if (pidx < n) ph[g] = phs_q[pidx];
            #1;
            if (iv[g] && ir[g]) begin
                exp_q.push_back({phs_q[pidx], ~phs_q[pidx]});
                if (acc_cyc < 0) acc_cyc = cyc;
                pidx++;
            end
            if (ov[g] && ordy[g]) begin
                if (last_done < 0) lat = cyc - acc_cyc - 1;
                else if (per < 0) per = cyc - last_done;
                last_done = cyc;
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_sin", 32'(os[g]), 32'(e[31:16]));
                    check("out_cos", 32'(oc[g]), 32'(e[15:0]));
                end
                exp_pc[g]++;
                ndone++;
            end
            step();
        end
        iv[g] = 1'b0;
        check("pairs_completed", ndone, n);
        check("pair_count", 32'(pc[g]), exp_pc[g] & pc_mask(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, per, pc0;
        logic [31:0] e;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; iv[i] = 1'b0; ordy[i] = 1'b1; ph[i] = '0; exp_pc[i] = 0;
        end
        step();

        // 1: single phase, TRIG_LAT=1
        do_reset(0);
        phs_q.delete(); phs_q.push_back(16'h4000);
        run(0, 40, lat, per);
        check("t1_latency", lat, 4);
        check("t1_in_ready_back", 32'(ir[0]), 1);
        check("t1_out_valid_low", 32'(ov[0]), 0);

        // 2: back-to-back phases
        do_reset(0);
        phs_q.delete();
        phs_q.push_back(16'h0000); phs_q.push_back(16'h08C0);
        phs_q.push_back(16'h3FFE); phs_q.push_back(16'h006E);
        run(0, 80, lat, per);
        check("t2_latency", lat, 4);
        check("t2_period", per, 6);
        check("t2_pair_count", 32'(pc[0]), 4);

        // 3: back-pressure in DONE, in_valid ignored outside IDLE
        ordy[0] = 1'b0;
        iv[0] = 1'b1; ph[0] = 16'h1234;
        #1;
        check("t3_in_ready", 32'(ir[0]), 1);
        exp_q.push_back({16'h1234, 16'hEDCB});
        step();
        ph[0] = 16'hAAAA;
        check("t3_sin_x", 32'(tx[0]), 32'h1234);
        check("t3_sin_func", 32'(tf[0]), 0);
        check("t3_busy", 32'(bsy[0]), 1);
        step(); step();
        check("t3_cos_func", 32'(tf[0]), 1);
        check("t3_cos_x", 32'(tx[0]), 32'h1234);
        step(); step();
        pc0 = 32'(pc[0]);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(ov[0]), 1);
            check("t3_hold_sin", 32'(os[0]), 32'h1234);
            check("t3_hold_cos", 32'(oc[0]), 32'hEDCB);
            check("t3_hold_in_ready", 32'(ir[0]), 0);
            check("t3_hold_x", 32'(tx[0]), 32'h1234);
            check("t3_hold_count", 32'(pc[0]), pc0);
            step();
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        e = exp_q.pop_front();
        check("t3_rel_sin", 32'(os[0]), 32'(e[31:16]));
        check("t3_rel_cos", 32'(oc[0]), 32'(e[15:0]));
        step();
        check("t3_count_inc", 32'(pc[0]), pc0 + 1);
        check("t3_valid_drop", 32'(ov[0]), 0);
        step(); step();
        check("t3_count_once", 32'(pc[0]), pc0 + 1);
        check("t3_idle", 32'(bsy[0]), 0);
        exp_pc[0] = pc0 + 1;

        // 4: reset pulse during COS
        iv[0] = 1'b1; ph[0] = 16'h2222;
        #1;
        check("t4_in_ready", 32'(ir[0]), 1);
        step();
        iv[0] = 1'b0;
        step(); step();
        check("t4_in_cos", 32'(tf[0]), 1);
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        #1;
        check("t4_busy", 32'(bsy[0]), 0);
        check("t4_out_valid", 32'(ov[0]), 0);
        check("t4_out_sin", 32'(os[0]), 0);
        check("t4_out_cos", 32'(oc[0]), 0);
        check("t4_trig_x", 32'(tx[0]), 0);
        check("t4_trig_func", 32'(tf[0]), 0);
        check("t4_pair_count", 32'(pc[0]), 0);
        check("t4_in_ready_after", 32'(ir[0]), 1);
        exp_q.delete();
        exp_pc[0] = 0;
        phs_q.delete(); phs_q.push_back(16'hC000);
        run(0, 40, lat, per);
        check("t4_latency", lat, 4);

        // 5: TRIG_LAT=0 and TRIG_LAT=3 builds
        do_reset(1);
        phs_q.delete(); phs_q.push_back(16'h1357); phs_q.push_back(16'hF00D);
        run(1, 40, lat, per);
        check("t5_lat0_latency", lat, 2);
        check("t5_lat0_period", per, 4);
        do_reset(2);
        phs_q.delete(); phs_q.push_back(16'h0F0F); phs_q.push_back(16'h8001);
        run(2, 60, lat, per);
        check("t5_lat3_latency", lat, 8);
        check("t5_lat3_period", per, 10);

        // 6: CNT_W=4 pair counter wraps
        do_reset(1);
        phs_q.delete();
        for (int i = 0; i < 15; i++) phs_q.push_back(16'(i * 16'h1111 + 7));
        run(1, 200, lat, per);
        check("t6_count15", 32'(pc[1]), 15);
        phs_q.delete(); phs_q.push_back(16'h5A5A);
        run(1, 20, lat, per);
        check("t6_wrap0", 32'(pc[1]), 0);
        phs_q.delete(); phs_q.push_back(16'hA5A5);
        run(1, 20, lat, per);
        check("t6_wrap1", 32'(pc[1]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
